screen_state_sequencer: RTL
===========================

// Module: screen_state_sequencer
// PURPOSE
//  Top-level game-flow controller. Owns the screen state and drives bgState into the
//  background generators (title / play / win / game-over).
//  Tracks lives and level, and times inter-level pauses and end screens in video frames.
//  Pulses levelLoad so the ball/player logic re-initialises the playfield.
// PARAMETERS
//  NUM_LIVES       3    lives granted at game start (1..3)
//  NUM_LEVELS      4    levels per game (1..4); clearing level NUM_LEVELS-1 wins
//  PAUSE_FRAMES    60   frames spent in PAUSE before PLAY resumes (>=1)
//  END_FRAMES      300  frames WIN/GAMEOVER is shown before auto-return to TITLE (>=1)
// PORTS
//  clk           in   1  system clock
//  resetN        in   1  synchronous reset, ACTIVE-HIGH (1 = reset), sampled on posedge clk
//  startOfFrame  in   1  one-cycle pulse, once per video frame
//  startKey      in   1  one-cycle pulse, debounced start button
//  playerHit     in   1  one-cycle pulse, player collided with a ball
//  levelClear    in   1  one-cycle pulse, last ball of the level destroyed
//  bgState       out  2  00 TITLE, 01 PLAY/PAUSE, 10 WIN, 11 GAMEOVER
//  level         out  2  current level index, 0-based
//  lives         out  2  remaining lives
//  gameActive    out  1  1 only in PLAY (enables player/ball motion)
//  levelLoad     out  1  one-cycle pulse: re-initialise playfield for current level
// BEHAVIOUR
//  - All outputs registered. Each input pulse takes effect on the next posedge;
//    outputs reflect the new state 1 cycle after the pulse is sampled.
//  - Reset (resetN=1 at posedge) forces:
//      state=TITLE, bgState=00, level=0, lives=0, gameActive=0, levelLoad=0, frameCnt=0.
//    Reset overrides every input and applies mid-game from any state.
//  - frameCnt (>= 9 bits) clears on every state transition and increments on
//    startOfFrame while in PAUSE, WIN or GAMEOVER.
//  - States and transitions:
//    TITLE:
//      startKey -> PAUSE; lives<=NUM_LIVES, level<=0, levelLoad pulse.
//    PAUSE:
//      startOfFrame while frameCnt==PAUSE_FRAMES-1 -> PLAY.
//      All other inputs ignored.
//    PLAY:
//      playerHit, lives>1  -> PAUSE; lives<=lives-1, level unchanged, levelLoad pulse.
//      playerHit, lives==1 -> GAMEOVER; lives<=0.
//      levelClear, level<NUM_LEVELS-1 -> PAUSE; level<=level+1, levelLoad pulse.
//      levelClear, level==NUM_LEVELS-1 -> WIN; level held.
//      playerHit and levelClear in the same cycle: playerHit wins, levelClear dropped.
//    WIN / GAMEOVER:
//      startKey -> TITLE.
//      startOfFrame while frameCnt==END_FRAMES-1 -> TITLE.
//      If both occur in the same cycle -> TITLE, once.
//  - levelLoad is high for exactly the 1 cycle following the triggering posedge,
//    never 2 cycles in a row.
//  - gameActive = (state==PLAY). bgState is a pure function of the registered state.
//  - Pulses arriving in a state that does not list them are ignored.
//    Nothing is queued or remembered.
//  - lives never underflows. level never exceeds NUM_LEVELS-1 and does not wrap.
// TESTING
//  1 Reset mid-PLAY (level=2, lives=1) -> next cycle:
//      bgState=00, level=0, lives=0, gameActive=0.
//  2 TITLE, startKey -> levelLoad=1 one cycle, lives=3, bgState=01, gameActive=0;
//      after 60 startOfFrame pulses -> gameActive=1.
//  3 PLAY lives=3, playerHit x3, with the PAUSE elapsed between hits:
//      lives 2, 1, then bgState=11, gameActive=0, no levelLoad on the third hit.
//  4 PLAY level=3, levelClear -> bgState=10, level stays 3;
//      after 300 frames -> bgState=00.
//  5 PLAY level=1 lives=2, playerHit and levelClear in the same cycle ->
//      lives=1, level=1, state PAUSE.
//  6 PAUSE, startKey/playerHit/levelClear pulses -> no change;
//      GAMEOVER, startKey at frame 10 -> TITLE next cycle.

Source files
------------

// File: rtl/screen_state_sequencer.sv
// Game-flow controller: owns the screen state (TITLE/PAUSE/PLAY/WIN/GAMEOVER),
// tracks lives and level, times pauses and end screens in video frames.
module screen_state_sequencer #(
    parameter int NUM_LIVES    = 3,
    parameter int NUM_LEVELS   = 4,
    parameter int PAUSE_FRAMES = 60,
    parameter int END_FRAMES   = 300
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startKey,
    input  logic       playerHit,
    input  logic       levelClear,
    output logic [1:0] bgState,
    output logic [1:0] level,
    output logic [1:0] lives,
    output logic       gameActive,
    output logic       levelLoad,
    output logic [2:0] state_dbg
);

    localparam int MAX_FRAMES = (PAUSE_FRAMES > END_FRAMES) ? PAUSE_FRAMES : END_FRAMES;
    localparam int CNT_W      = ($clog2(MAX_FRAMES + 1) > 9) ? $clog2(MAX_FRAMES + 1) : 9;

    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_FRAMES - 1);
    localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(END_FRAMES - 1);
    localparam logic [1:0]       LIVES_INIT = 2'(NUM_LIVES);
    localparam logic [1:0]       LEVEL_LAST = 2'(NUM_LEVELS - 1);

    localparam logic [2:0] ST_TITLE    = 3'd0;
    localparam logic [2:0] ST_PAUSE    = 3'd1;
    localparam logic [2:0] ST_PLAY     = 3'd2;
    localparam logic [2:0] ST_WIN      = 3'd3;
    localparam logic [2:0] ST_GAMEOVER = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]       level_q, level_d;
    logic [1:0]       lives_q, lives_d;
    logic [1:0]       bg_state_q, bg_state_d;
    logic             game_active_q, game_active_d;
    logic             level_load_q, level_load_d;
    logic             load_req;
    logic             frame_counting;
    logic             state_change;

    // Next-state and score bookkeeping; playerHit takes priority over levelClear.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        lives_d  = lives_q;
        load_req = 1'b0;
        case (state_q)
            ST_TITLE: begin
                if (startKey) begin
                    state_d  = ST_PAUSE;
                    lives_d  = LIVES_INIT;
                    level_d  = 2'd0;
                    load_req = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (startOfFrame && (frame_cnt_q == PAUSE_LAST)) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (playerHit) begin
                    if (lives_q > 2'd1) begin
                        state_d  = ST_PAUSE;
                        lives_d  = lives_q - 2'd1;
                        load_req = 1'b1;
                    end else begin
                        state_d = ST_GAMEOVER;
                        lives_d = 2'd0;
                    end
                end else if (levelClear) begin
                    if (level_q < LEVEL_LAST) begin
                        state_d  = ST_PAUSE;
                        level_d  = level_q + 2'd1;
                        load_req = 1'b1;
                    end else begin
                        state_d = ST_WIN;
                    end
                end
            end
            ST_WIN, ST_GAMEOVER: begin
                if (startKey || (startOfFrame && (frame_cnt_q == END_LAST))) begin
                    state_d = ST_TITLE;
                end
            end
            default: state_d = ST_TITLE;
        endcase
    end

    // Frame counter restarts on every screen change so each timed screen starts at 0.
    always_comb begin
        state_change   = (state_d != state_q);
        frame_counting = (state_q == ST_PAUSE) || (state_q == ST_WIN) ||
                         (state_q == ST_GAMEOVER);
        frame_cnt_d    = frame_cnt_q;
        if (state_change) begin
            frame_cnt_d = '0;
        end else if (frame_counting && startOfFrame) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they land together with it.
    always_comb begin
        bg_state_d = 2'b00;
        case (state_d)
            ST_TITLE:          bg_state_d = 2'b00;
            ST_PAUSE, ST_PLAY: bg_state_d = 2'b01;
            ST_WIN:            bg_state_d = 2'b10;
            ST_GAMEOVER:       bg_state_d = 2'b11;
            default:           bg_state_d = 2'b00;
        endcase
        game_active_d = (state_d == ST_PLAY);
        level_load_d  = load_req && !level_load_q;
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q       <= ST_TITLE;
            frame_cnt_q   <= '0;
            level_q       <= 2'd0;
            lives_q       <= 2'd0;
            bg_state_q    <= 2'b00;
            game_active_q <= 1'b0;
            level_load_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            bg_state_q    <= bg_state_d;
            game_active_q <= game_active_d;
            level_load_q  <= level_load_d;
        end
    end

    assign bgState    = bg_state_q;
    assign level      = level_q;
    assign lives      = lives_q;
    assign gameActive = game_active_q;
    assign levelLoad  = level_load_q;
    assign state_dbg  = state_q;

endmodule
